// File: rtl/int_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : int_subtractor
// Purpose  : Two-stage handshaked SIMD integer subtractor with split and
//            widening forms over 8/16/32/64-bit lanes and per-lane borrows.
// Revision : 1.0
// ============================================================================
module int_subtractor #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        form,
    input  logic [1:0]  precision,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [31:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Y1,
    output logic [31:0] Y2,
    output logic [3:0]  borrow1,
    output logic [3:0]  borrow2
);

    logic        r_s1_valid;
    logic        r_s1_form;
    logic [1:0]  r_s1_prec;
    logic [31:0] r_s1_a, r_s1_b, r_s1_c, r_s1_d;

    logic        r_s2_valid;
    logic [31:0] r_s2_y1, r_s2_y2;
    logic [3:0]  r_s2_b1, r_s2_b2;

    logic        w_s1_free, w_s2_free, w_accept;
    logic [31:0] w_y1_p0, w_y2_p0, w_y1_p1, w_y2_p1;
    logic [3:0]  w_b1_p0, w_b2_p0;
    logic [1:0]  w_b1_p1, w_b2_p1;
    logic [32:0] w_da32, w_db32;
    logic [63:0] w_wd32;
    logic [64:0] w_d64;
    logic [31:0] w_y1, w_y2;
    logic [3:0]  w_b1, w_b2;

    // Each lane carries one extra MSB so the borrow drops out of the subtract.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane8
        logic [8:0]  w_da, w_db;
        logic [15:0] w_wd;
        assign w_da = {1'b0, r_s1_a[gi*8 +: 8]} - {1'b0, r_s1_c[gi*8 +: 8]};
        assign w_db = {1'b0, r_s1_b[gi*8 +: 8]} - {1'b0, r_s1_d[gi*8 +: 8]};
        assign w_wd = {8'd0, r_s1_a[gi*8 +: 8]} - {8'd0, r_s1_b[gi*8 +: 8]}
                    - {8'd0, r_s1_c[gi*8 +: 8]};
        assign w_y1_p0[gi*8 +: 8] = r_s1_form ? w_da[7:0] : w_wd[15:8];
        assign w_y2_p0[gi*8 +: 8] = r_s1_form ? w_db[7:0] : w_wd[7:0];
        assign w_b1_p0[gi]        = r_s1_form ? w_da[8]   : w_wd[15];
        assign w_b2_p0[gi]        = r_s1_form & w_db[8];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane16
        logic [16:0] w_da, w_db;
        logic [31:0] w_wd;
        assign w_da = {1'b0, r_s1_a[gi*16 +: 16]} - {1'b0, r_s1_c[gi*16 +: 16]};
        assign w_db = {1'b0, r_s1_b[gi*16 +: 16]} - {1'b0, r_s1_d[gi*16 +: 16]};
        assign w_wd = {16'd0, r_s1_a[gi*16 +: 16]} - {16'd0, r_s1_b[gi*16 +: 16]}
                    - {16'd0, r_s1_c[gi*16 +: 16]};
        assign w_y1_p1[gi*16 +: 16] = r_s1_form ? w_da[15:0] : w_wd[31:16];
        assign w_y2_p1[gi*16 +: 16] = r_s1_form ? w_db[15:0] : w_wd[15:0];
        assign w_b1_p1[gi]          = r_s1_form ? w_da[16]   : w_wd[31];
        assign w_b2_p1[gi]          = r_s1_form & w_db[16];
    end

    assign w_da32 = {1'b0, r_s1_a} - {1'b0, r_s1_c};
    assign w_db32 = {1'b0, r_s1_b} - {1'b0, r_s1_d};
    assign w_wd32 = {32'd0, r_s1_a} - {32'd0, r_s1_b} - {32'd0, r_s1_c};
    assign w_d64  = {1'b0, r_s1_a, r_s1_b} - {1'b0, r_s1_c, r_s1_d};

    // Lane flags sit on the lane's most-significant byte slot.
    always_comb begin
        w_y1 = '0;
        w_y2 = '0;
        w_b1 = '0;
        w_b2 = '0;
        case (r_s1_prec)
            2'd0: begin
                w_y1 = w_y1_p0;
                w_y2 = w_y2_p0;
                w_b1 = w_b1_p0;
                w_b2 = w_b2_p0;
            end
            2'd1: begin
                w_y1 = w_y1_p1;
                w_y2 = w_y2_p1;
                w_b1 = {w_b1_p1[1], 1'b0, w_b1_p1[0], 1'b0};
                w_b2 = {w_b2_p1[1], 1'b0, w_b2_p1[0], 1'b0};
            end
            2'd2: begin
                w_y1 = r_s1_form ? w_da32[31:0] : w_wd32[63:32];
                w_y2 = r_s1_form ? w_db32[31:0] : w_wd32[31:0];
                w_b1 = {(r_s1_form ? w_da32[32] : w_wd32[63]), 3'b000};
                w_b2 = {(r_s1_form & w_db32[32]), 3'b000};
            end
            default: begin
                w_y1 = w_d64[63:32];
                w_y2 = w_d64[31:0];
                w_b1 = {w_d64[64], 3'b000};
            end
        endcase
    end

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    // Only the two-stage pipe exists; other depths leave the block inert.
    if (LATENCY == 2) begin : g_lat_ok
        assign in_ready = w_s1_free;
    end else begin : g_lat_unsupported
        assign in_ready = 1'b0;
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_form  <= 1'b0;
            r_s1_prec  <= 2'd0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_d     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_y1    <= '0;
            r_s2_y2    <= '0;
            r_s2_b1    <= '0;
            r_s2_b2    <= '0;
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_form <= form;
                    r_s1_prec <= precision;
                    r_s1_a    <= A;
                    r_s1_b    <= B;
                    r_s1_c    <= C;
                    r_s1_d    <= D;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_y1 <= w_y1;
                    r_s2_y2 <= w_y2;
                    r_s2_b1 <= w_b1;
                    r_s2_b2 <= w_b2;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign Y1        = r_s2_y1;
    assign Y2        = r_s2_y2;
    assign borrow1   = r_s2_b1;
    assign borrow2   = r_s2_b2;

endmodule
`default_nettype wire

// File: tb/tb_int_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_subtractor
// Purpose  : Directed and randomised self-checking bench for int_subtractor.
// Revision : 1.0
// ============================================================================
module tb_int_subtractor;

    typedef struct packed {
        logic        f;
        logic [1:0]  p;
        logic [31:0] a, b, c, d;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        form = 1'b0;
    logic [1:0]  precision = 2'd0;
    logic [31:0] A = '0, B = '0, C = '0, D = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Y1, Y2;
    logic [3:0]  borrow1, borrow2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [71:0] sb_q[$];
    logic [71:0] sb_exp;
    op_t         ops10[10];
    op_t         stall_ops[3];
    op_t         rop;

    int_subtractor #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .form(form), .precision(precision), .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .Y1(Y1), .Y2(Y2),
        .borrow1(borrow1), .borrow2(borrow2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: generic lane arithmetic on 64-bit masked values.
    function automatic logic [71:0] model(input op_t o);
        logic [31:0] y1, y2;
        logic [3:0]  b1, b2;
        logic [63:0] ab, cd, la, lb, lc, ld, w, m1, m2;
        int          n, fi;
        y1 = '0; y2 = '0; b1 = '0; b2 = '0;
        if (o.p == 2'd3) begin
            ab = {o.a, o.b};
            cd = {o.c, o.d};
            {y1, y2} = ab - cd;
            b1[3] = (ab < cd);
        end else begin
            n  = 8 << o.p;
            m1 = (64'd1 << n) - 64'd1;
            m2 = (64'd1 << (2 * n)) - 64'd1;
            for (int i = 0; i < 32 / n; i++) begin
                la = (64'(o.a) >> (i * n)) & m1;
                lb = (64'(o.b) >> (i * n)) & m1;
                lc = (64'(o.c) >> (i * n)) & m1;
                ld = (64'(o.d) >> (i * n)) & m1;
                fi = ((i + 1) * n) / 8 - 1;
                if (o.f) begin
                    y1 = y1 | 32'(((la - lc) & m1) << (i * n));
                    y2 = y2 | 32'(((lb - ld) & m1) << (i * n));
                    b1[fi] = (la < lc);
                    b2[fi] = (lb < ld);
                end else begin
                    w  = (la - lb - lc) & m2;
                    y1 = y1 | 32'(((w >> n) & m1) << (i * n));
                    y2 = y2 | 32'((w & m1) << (i * n));
                    b1[fi] = w[2 * n - 1];
                end
            end
        end
        return {y1, y2, b1, b2};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.f = 1'($urandom_range(0, 1));
        o.p = 2'($urandom_range(0, 3));
        o.a = rnd32(); o.b = rnd32(); o.c = rnd32(); o.d = rnd32();
        return o;
    endfunction

    task automatic drive(input op_t o);
        form = o.f; precision = o.p; A = o.a; B = o.b; C = o.c; D = o.d;
    endtask

    // Scoreboard: every accept pushes the model result, every output transfer pops.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 72'(sb_q.size() != 0), 72'd1);
                if (sb_q.size() != 0) begin
                    sb_exp = sb_q.pop_front();
                    check("sb_data", {Y1, Y2, borrow1, borrow2}, sb_exp);
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model('{form, precision, A, B, C, D}));
        end
    end

    task automatic run_op(input string tag, input op_t o, input logic [31:0] ey1,
                          input logic [31:0] ey2, input logic [3:0] eb1, input logic [3:0] eb2);
        drive(o);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 72'(in_ready), 72'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~A; B = ~B; C = ~C; D = ~D; form = ~form; precision = precision + 2'd1;
        check({tag, "_lat1"}, 72'(out_valid), 72'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 72'(out_valid), 72'd1);
        check({tag, "_Y1"}, 72'(Y1), 72'(ey1));
        check({tag, "_Y2"}, 72'(Y2), 72'(ey2));
        check({tag, "_b1"}, 72'(borrow1), 72'(eb1));
        check({tag, "_b2"}, 72'(borrow2), 72'(eb2));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int cyc;
        for (int k = 0; k < 10; k++) begin
            ops10[k]   = rnd_op();
            ops10[k].f = 1'(k);
            ops10[k].p = 2'(k);
        end
        for (int k = 0; k < 3; k++) stall_ops[k] = rnd_op();

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 72'(out_valid), 72'd0);
        check("rst_outputs", {Y1, Y2, borrow1, borrow2}, 72'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", 72'(in_ready), 72'd1);
        @(posedge clk); #1;

        // Directed vectors
        run_op("split_p0", '{1'b1, 2'd0, 32'h0510FF00, 32'h0, 32'h06010001, 32'h0},
               32'hFF0FFFFF, 32'h0, 4'b1001, 4'b0000);
        run_op("widen_p1_neg", '{1'b0, 2'd1, 32'h00010005, 32'h00020002, 32'h00000004, 32'h0},
               32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010, 4'b0000);
        run_op("widen_p1_mix", '{1'b0, 2'd1, 32'h00010005, 32'h00020002, 32'h00000002, 32'h0},
               32'hFFFF0000, 32'hFFFF0001, 4'b1000, 4'b0000);
        run_op("p64_pos", '{1'b0, 2'd3, 32'h00000001, 32'h0, 32'h0, 32'h00000001},
               32'h00000000, 32'hFFFFFFFF, 4'b0000, 4'b0000);
        run_op("p64_neg", '{1'b1, 2'd3, 32'h0, 32'h00000001, 32'h00000001, 32'h0},
               32'hFFFFFFFF, 32'h00000001, 4'b1000, 4'b0000);
        run_op("widen_p0", '{1'b0, 2'd0, 32'h01FF0500, 32'hFF000302, 32'hFF000101, 32'hDEADBEEF},
               32'hFE0000FF, 32'h03FF01FD, 4'b1001, 4'b0000);
        run_op("split_p1", '{1'b1, 2'd1, 32'h12340000, 32'h80000001, 32'h12350001, 32'h7FFF0002},
               32'hFFFFFFFF, 32'h0001FFFF, 4'b1010, 4'b0010);
        run_op("split_p2", '{1'b1, 2'd2, 32'h5, 32'h7, 32'h7, 32'h5},
               32'hFFFFFFFE, 32'h00000002, 4'b1000, 4'b0000);
        run_op("widen_p2_neg", '{1'b0, 2'd2, 32'h5, 32'h3, 32'h4, 32'h0},
               32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 4'b0000);
        run_op("widen_p2_pos", '{1'b0, 2'd2, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0},
               32'h00000000, 32'hFFFFFFFF, 4'b0000, 4'b0000);

        // Back-to-back with per-op mode changes
        out_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) begin
                drive(ops10[k]);
                in_valid = 1'b1;
                check("b2b_in_ready", 72'(in_ready), 72'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (k >= 1) begin
                check("b2b_valid", 72'(out_valid), 72'd1);
                check("b2b_data", {Y1, Y2, borrow1, borrow2}, model(ops10[k-1]));
            end
        end
        @(posedge clk); #1;
        check("b2b_drained", 72'(out_valid), 72'd0);

        // Stall: two accepts fill the pipe, then outputs freeze
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            drive(stall_ops[acc]);
            in_valid = 1'b1;
            #1;
            if (k >= 2) begin
                check("stall_in_ready", 72'(in_ready), 72'd0);
                check("stall_hold", {Y1, Y2, borrow1, borrow2}, model(stall_ops[0]));
                check("stall_valid", 72'(out_valid), 72'd1);
            end
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("stall_accepts", 72'(acc), 72'd2);
        out_ready = 1'b1;
        #1 check("release_in_ready", 72'(in_ready), 72'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("stall_sb_empty", 72'(sb_q.size()), 72'd0);

        // Reset with two operations in flight
        out_ready = 1'b0;
        drive(rnd_op());
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(rnd_op());
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_valid", 72'(out_valid), 72'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 72'(out_valid), 72'd0);
        check("mid_rst_outputs", {Y1, Y2, borrow1, borrow2}, 72'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_out", 72'(out_valid), 72'd0);
        end

        // Random traffic with random back-pressure
        acc = 0;
        cyc = 0;
        while (acc < 300 && cyc < 5000) begin
            rop = rnd_op();
            drive(rop);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_accepts", 72'(acc), 72'd300);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_drained", 72'(sb_q.size()), 72'd0);
        @(posedge clk); #1;
        check("rand_idle", 72'(out_valid), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
